dequantize_array: RTL and testbench

Inverse of the tile quantizer in the qgemm datapath. It accepts one set of per-row scales, then one MAT_SIZE×MAT_SIZE tile of sign-extended BIT_NUM-bit integers streamed LANES_NUM per beat in row-major order. Each element is reconstructed to IEEE-754 single precision using its row's scale. The block sits between the integer GEMM result path and FP consumers. It has a one-stage output register with full valid/ready backpressure.

---
 rtl/dequantize_array_if.sv | 29 ++
 rtl/dequantize_array.sv | 190 +++++++++++++++++++
 tb/tb_dequantize_array.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dequantize_array_if.sv
// rtl/dequantize_array_if.sv - scale, quantized-input and FP-output handshakes for dequantize_array
interface dequantize_array_if #(
    parameter int MAT_SIZE  = 16,
    parameter int FP_DATA_W = 32,
    parameter int FP_EXP_W  = 8,
    parameter int FP_MANT_W = 23,
    parameter int LANES_NUM = 16
);
    logic                              scl_valid_i;
    logic                              scl_ready_o;
    logic [FP_MANT_W*MAT_SIZE-1:0]     mantissa_scale_i;
    logic [FP_EXP_W*MAT_SIZE-1:0]      exp_scale_i;
    logic                              s_valid_i;
    logic                              s_ready_o;
    logic [LANES_NUM*FP_DATA_W-1:0]    s_data_i;
    logic                              m_valid_o;
    logic                              m_ready_i;
    logic [LANES_NUM*FP_DATA_W-1:0]    m_data_o;

    modport slave (
        input  scl_valid_i, mantissa_scale_i, exp_scale_i, s_valid_i, s_data_i, m_ready_i,
        output scl_ready_o, s_ready_o, m_valid_o, m_data_o
    );

    modport master (
        output scl_valid_i, mantissa_scale_i, exp_scale_i, s_valid_i, s_data_i, m_ready_i,
        input  scl_ready_o, s_ready_o, m_valid_o, m_data_o
    );
endinterface

// File: rtl/dequantize_array.sv
// rtl/dequantize_array.sv - per-row scaled int-to-FP32 tile dequantizer; optional lane check via DEQUANT_LANE_CHECK_EN
module dequantize_array #(
    parameter int BIT_NUM     = 8,
    parameter int MAT_SIZE    = 16,
    parameter int FP_DATA_W   = 32,
    parameter int FP_EXP_W    = 8,
    parameter int FP_MANT_W   = 23,
    parameter int FP_EXP_BIAS = 127,
    parameter int LANES_NUM   = 16
) (
    input  logic clk,
    input  logic rstnn,
    dequantize_array_if.slave bus
`ifdef DEQUANT_LANE_CHECK_EN
    ,
    output logic err_o
`endif
);
    localparam int IN_BEATS = (MAT_SIZE * MAT_SIZE) / LANES_NUM;
    localparam int BEAT_W   = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int ROW_W    = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;
    localparam int P_W      = BIT_NUM + FP_MANT_W + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IN_BEATS - 1);

    generate
        if (((MAT_SIZE * MAT_SIZE) % LANES_NUM) != 0) begin : g_bad_lanes
            $fatal(1, "dequantize_array: MAT_SIZE*MAT_SIZE must be a multiple of LANES_NUM");
        end
    endgenerate

    typedef enum logic {S_SCALE, S_RUN} state_t;

    state_t                          r_state, w_state_nxt;
    logic [BEAT_W-1:0]               r_beat, w_beat_nxt;
    logic [FP_MANT_W-1:0]            r_mant [MAT_SIZE];
    logic [FP_EXP_W-1:0]             r_exp  [MAT_SIZE];
    logic                            r_m_valid;
    logic [LANES_NUM*FP_DATA_W-1:0]  r_m_data;
    logic [LANES_NUM*FP_DATA_W-1:0]  w_deq;
    logic                            w_scl_ready;
    logic                            w_s_ready;
    logic                            w_scl_fire;
    logic                            w_push;
    logic                            w_pop;

    // Scale is (1.mant)*2^(E-bias); q is a fixed-point fraction q/2^(BIT_NUM-1).
    // The bias cancels because E is carried through unchanged; only the fraction and product shifts matter.
    function automatic logic [FP_DATA_W-1:0] f_deq(
        input logic [BIT_NUM-1:0]   q,
        input logic [FP_MANT_W-1:0] mant,
        input logic [FP_EXP_W-1:0]  e
    );
        logic               sgn;
        logic [BIT_NUM-1:0] mag;
        logic [P_W-1:0]     prod;
        int                 p;
        int                 rexp;
        sgn  = q[BIT_NUM-1];
        mag  = sgn ? (~q + BIT_NUM'(1)) : q;
        prod = P_W'(mag) * P_W'({1'b1, mant});
        p    = 0;
        for (int i = 0; i < P_W; i++) begin
            if (prod[i]) p = i;
        end
        rexp = int'(e) - (BIT_NUM - 1) + (p - FP_MANT_W);
        if (q == '0 || e == '0)
            f_deq = '0;
        else if (&e)
            f_deq = {sgn, {FP_EXP_W{1'b1}}, {FP_MANT_W{1'b0}}};
        else if (rexp <= 0)
            f_deq = {sgn, {(FP_DATA_W-1){1'b0}}};
        else
            f_deq = {sgn, FP_EXP_W'(rexp),
                     FP_MANT_W'((prod << (P_W - 1 - p)) >> (P_W - 1 - FP_MANT_W))};
    endfunction

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state <= S_SCALE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_scl_ready = 1'b0;
        w_s_ready   = 1'b0;
        case (r_state)
            S_SCALE: begin
                w_scl_ready = 1'b1;
                if (bus.scl_valid_i) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_s_ready = !r_m_valid || bus.m_ready_i;
                if (bus.s_valid_i && w_s_ready) begin
                    if (r_beat == LAST_BEAT) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = S_SCALE;
                    end else begin
                        w_beat_nxt = r_beat + BEAT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_SCALE;
        endcase
    end

    assign w_scl_fire = bus.scl_valid_i && w_scl_ready;
    assign w_push     = bus.s_valid_i && w_s_ready;
    assign w_pop      = r_m_valid && bus.m_ready_i;

    // A new scale may land while the last beat of the previous tile still sits in the output register.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int k = 0; k < MAT_SIZE; k++) begin
                r_mant[k] <= '0;
                r_exp[k]  <= '0;
            end
        end else if (w_scl_fire) begin
            for (int k = 0; k < MAT_SIZE; k++) begin
                r_mant[k] <= bus.mantissa_scale_i[k*FP_MANT_W +: FP_MANT_W];
                r_exp[k]  <= bus.exp_scale_i[k*FP_EXP_W +: FP_EXP_W];
            end
        end
    end

    always_comb begin : p_lanes
        logic [ROW_W-1:0] v_row;
        w_deq = '0;
        v_row = '0;
        for (int l = 0; l < LANES_NUM; l++) begin
            v_row = ROW_W'((int'(r_beat) * LANES_NUM + l) / MAT_SIZE);
            w_deq[l*FP_DATA_W +: FP_DATA_W] =
                f_deq(bus.s_data_i[l*FP_DATA_W +: BIT_NUM], r_mant[v_row], r_exp[v_row]);
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (w_push) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_deq;
        end else if (w_pop) begin
            r_m_valid <= 1'b0;
        end
    end

    assign bus.scl_ready_o = w_scl_ready;
    assign bus.s_ready_o   = w_s_ready;
    assign bus.m_valid_o   = r_m_valid;
    assign bus.m_data_o    = r_m_data;

`ifdef DEQUANT_LANE_CHECK_EN
    logic r_err;
    logic w_lane_bad;

    // Upper lane bits must be a pure sign extension of the BIT_NUM-bit value.
    always_comb begin
        w_lane_bad = 1'b0;
        for (int l = 0; l < LANES_NUM; l++) begin
            if (bus.s_data_i[l*FP_DATA_W+BIT_NUM +: FP_DATA_W-BIT_NUM] !=
                {(FP_DATA_W-BIT_NUM){bus.s_data_i[l*FP_DATA_W+BIT_NUM-1]}})
                w_lane_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn)
            r_err <= 1'b0;
        else if (w_push && w_lane_bad)
            r_err <= 1'b1;
    end

    assign err_o = r_err;
`else
    logic w_unused_hi;

    always_comb begin
        w_unused_hi = 1'b0;
        for (int l = 0; l < LANES_NUM; l++)
            w_unused_hi = w_unused_hi ^ (^bus.s_data_i[l*FP_DATA_W+BIT_NUM +: FP_DATA_W-BIT_NUM]);
    end
`endif
endmodule

// File: tb/tb_dequantize_array.sv
// tb/tb_dequantize_array.sv - directed self-checking bench for dequantize_array
module tb_dequantize_array;
    logic clk = 1'b0;
    logic rstnn;

    always #5 clk = ~clk;

    dequantize_array_if bus ();
`ifdef DEQUANT_LANE_CHECK_EN
    logic err_o;
`endif

    dequantize_array dut (
        .clk   (clk),
        .rstnn (rstnn),
        .bus   (bus)
`ifdef DEQUANT_LANE_CHECK_EN
        ,
        .err_o (err_o)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] bp_tab [16];
    logic [3:0]  bp_pat;
    logic        exp_valid, exp_sready, push, pop;
    int          exp_beat, nb, nr, cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane(input int l);
        return bus.m_data_o[l*32 +: 32];
    endfunction

    task automatic set_lane(input int l, input logic [31:0] v);
        bus.s_data_i[l*32 +: 32] = v;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int l = 0; l < 16; l++) set_lane(l, v);
    endtask

    task automatic set_scale(input int r, input logic [7:0] e, input logic [22:0] m);
        bus.exp_scale_i[r*8 +: 8]       = e;
        bus.mantissa_scale_i[r*23 +: 23] = m;
    endtask

    task automatic set_all_scale(input logic [7:0] e, input logic [22:0] m);
        for (int r = 0; r < 16; r++) set_scale(r, e, m);
    endtask

    task automatic send_scale();
        bus.scl_valid_i = 1'b1;
        #2 chk("scl_ready_idle", bus.scl_ready_o, 1);
        tick();
        bus.scl_valid_i = 1'b0;
        chk("scl_ready_run", bus.scl_ready_o, 0);
    endtask

    task automatic push_beat();
        bus.s_valid_i = 1'b1;
        #2 chk("s_ready_run", bus.s_ready_o, 1);
        tick();
        bus.s_valid_i = 1'b0;
        chk("m_valid_push", bus.m_valid_o, 1);
    endtask

    task automatic chk_reset_state();
        chk("rst_m_valid", bus.m_valid_o, 0);
        chk("rst_m_data_any", {31'b0, |bus.m_data_o}, 0);
        chk("rst_scl_ready", bus.scl_ready_o, 1);
        chk("rst_s_ready", bus.s_ready_o, 0);
`ifdef DEQUANT_LANE_CHECK_EN
        chk("rst_err", err_o, 0);
`endif
    endtask

    initial begin
        bp_tab[0]  = 32'h3C000000; bp_tab[1]  = 32'h3C800000; bp_tab[2]  = 32'h3CC00000;
        bp_tab[3]  = 32'h3D000000; bp_tab[4]  = 32'h3D200000; bp_tab[5]  = 32'h3D400000;
        bp_tab[6]  = 32'h3D600000; bp_tab[7]  = 32'h3D800000; bp_tab[8]  = 32'h3D900000;
        bp_tab[9]  = 32'h3DA00000; bp_tab[10] = 32'h3DB00000; bp_tab[11] = 32'h3DC00000;
        bp_tab[12] = 32'h3DD00000; bp_tab[13] = 32'h3DE00000; bp_tab[14] = 32'h3DF00000;
        bp_tab[15] = 32'h3E000000;
        bp_pat = 4'b1001;

        rstnn = 1'b0;
        bus.scl_valid_i = 1'b0; bus.mantissa_scale_i = '0; bus.exp_scale_i = '0;
        bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.m_ready_i = 1'b1;
        tick(); tick();
        chk_reset_state();
        rstnn = 1'b1;
        tick();

        // Tile 1: uniform unit scale, basic lane values
        set_all_scale(8'd127, 23'h0);
        send_scale();
        for (int l = 0; l < 16; l++)
            set_lane(l, (l % 4 == 0) ? 32'h40 : (l % 4 == 1) ? 32'hFFFFFF80 : (l % 4 == 2) ? 32'h0 : 32'h1);
        push_beat();
        chk("t1_q64", lane(0), 32'h3F000000);
        chk("t1_qm128", lane(1), 32'hBF800000);
        chk("t1_q0", lane(2), 32'h00000000);
        chk("t1_q1", lane(3), 32'h3C000000);
        chk("t1_qm128_l13", lane(13), 32'hBF800000);
        fill(32'h1);
        for (int b = 1; b < 16; b++) begin
            push_beat();
            chk("t1_stream", lane(15), 32'h3C000000);
        end
        chk("t1_back_scale", bus.scl_ready_o, 1);
        chk("t1_s_ready_idle", bus.s_ready_o, 0);
        tick();
        chk("t1_drain", bus.m_valid_o, 0);
`ifdef DEQUANT_LANE_CHECK_EN
        chk("t1_err_clean", err_o, 0);
`endif

        // Tile 2: per-row scales and edge cases
        set_all_scale(8'd127, 23'h0);
        set_scale(0, 8'd127, 23'h400000);
        set_scale(1, 8'd128, 23'h0);
        set_scale(2, 8'd3, 23'h0);
        set_scale(3, 8'd255, 23'h0);
        set_scale(4, 8'd0, 23'h123456);
        send_scale();
        fill(32'd127); set_lane(1, 32'hFFFFFFFF);
        push_beat();
        chk("t2_row0_l0", lane(0), 32'h3FBE8000);
        chk("t2_row0_qm1", lane(1), 32'hBC400000);
        chk("t2_row0_l15", lane(15), 32'h3FBE8000);
        fill(32'd127); set_lane(1, 32'd3);
        push_beat();
        chk("t2_row1_l0", lane(0), 32'h3FFE0000);
        chk("t2_row1_q3", lane(1), 32'h3D400000);
        chk("t2_row1_l15", lane(15), 32'h3FFE0000);
        fill(32'h0); set_lane(0, 32'h1); set_lane(1, 32'hFFFFFFFF);
        push_beat();
        chk("t2_flush_pos", lane(0), 32'h00000000);
        chk("t2_flush_neg", lane(1), 32'h80000000);
        chk("t2_zero_q", lane(2), 32'h00000000);
        fill(32'h0); set_lane(0, 32'hFFFFFFFB); set_lane(1, 32'd5);
        push_beat();
        chk("t2_inf_neg", lane(0), 32'hFF800000);
        chk("t2_inf_pos", lane(1), 32'h7F800000);
        chk("t2_inf_q0", lane(2), 32'h00000000);
        fill(32'hFFFFFF80);
        push_beat();
        chk("t2_e0", lane(0), 32'h00000000);
        for (int b = 5; b < 16; b++) begin
            push_beat();
            chk("t2_most_neg", lane(7), 32'hBF800000);
        end
        tick();

        // Tile 3: backpressure with m_ready pattern 1/0/0/1
        set_all_scale(8'd127, 23'h0);
        send_scale();
        exp_valid = 1'b0; exp_beat = 0; nb = 0; nr = 0; cyc = 0;
        while (nb < 16 && cyc < 200) begin
            bus.m_ready_i = bp_pat[cyc % 4];
            bus.s_valid_i = 1'b1;
            fill(32'(nb + 1));
            #2;
            exp_sready = !exp_valid || bus.m_ready_i;
            chk("bp_s_ready", bus.s_ready_o, exp_sready);
            chk("bp_m_valid", bus.m_valid_o, exp_valid);
            if (exp_valid) begin
                chk("bp_lane0", lane(0), bp_tab[exp_beat]);
                chk("bp_lane15", lane(15), bp_tab[exp_beat]);
            end
            push = exp_sready;
            pop  = exp_valid && bus.m_ready_i;
            tick();
            if (pop) nr++;
            if (push) begin
                exp_valid = 1'b1;
                exp_beat  = nb;
                nb++;
            end else if (pop) begin
                exp_valid = 1'b0;
            end
            cyc++;
        end
        bus.s_valid_i = 1'b0;
        chk("bp_all_pushed", nb, 16);

        // New scale accepted while the final beat is stalled
        set_all_scale(8'd128, 23'h0);
        bus.m_ready_i = 1'b0;
        bus.scl_valid_i = 1'b1;
        #2;
        chk("b2b_scl_ready", bus.scl_ready_o, 1);
        chk("b2b_pending", bus.m_valid_o, 1);
        tick();
        bus.scl_valid_i = 1'b0;
        chk("b2b_held_valid", bus.m_valid_o, 1);
        chk("b2b_held_data", lane(0), 32'h3E000000);
        chk("b2b_in_run", bus.scl_ready_o, 0);
        chk("b2b_s_ready_stall", bus.s_ready_o, 0);
        bus.m_ready_i = 1'b1;
        #1 chk("b2b_s_ready_pop", bus.s_ready_o, 1);
        tick();
        nr++;
        chk("b2b_drained", bus.m_valid_o, 0);
        chk("bp_pops", nr, 16);

        // Tile 4 uses the new scales, then reset after beat 7
        fill(32'h1); set_lane(2, 32'd16);
        for (int b = 0; b < 8; b++) begin
            push_beat();
            chk("t4_new_scale", lane(0), 32'h3C800000);
            chk("t4_q16", lane(2), 32'h3E800000);
        end
        #2 rstnn = 1'b0;
        #1 chk_reset_state();
        tick();
        rstnn = 1'b1;
        tick();

        // Tile 5: full tile after reset; lane with bad sign extension
        set_all_scale(8'd129, 23'h0);
        send_scale();
        for (int b = 0; b < 16; b++) begin
            fill(32'h1); set_lane(1, 32'hFFFFFFFD);
            if (b == 3) set_lane(2, 32'h00000180);
            push_beat();
            chk("t5_q1", lane(0), 32'h3D000000);
            chk("t5_qm3", lane(1), 32'hBDC00000);
            if (b == 3) chk("t5_bad_lane_data", lane(2), 32'hC0800000);
`ifdef DEQUANT_LANE_CHECK_EN
            chk("t5_err", err_o, (b >= 3) ? 32'd1 : 32'd0);
`endif
        end
        chk("t5_back_scale", bus.scl_ready_o, 1);
        tick();
        chk("t5_drain", bus.m_valid_o, 0);
        #2 rstnn = 1'b0;
        #1 chk_reset_state();
        tick();
        rstnn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
